// File: rtl/csa_resolve_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_resolve_pipe_if : redundant-pair in / binary result out handshake    |
// | Optional build macro: CSA_RESOLVE_ZERO_EN (adds the zero flag)           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface csa_resolve_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] res;
`ifdef CSA_RESOLVE_ZERO_EN
    logic             zero;
`endif

    modport slave (
        input  in_valid, s_in, c_in, out_ready,
        output in_ready, out_valid, res
`ifdef CSA_RESOLVE_ZERO_EN
        , output zero
`endif
    );

    modport master (
        output in_valid, s_in, c_in, out_ready,
        input  in_ready, out_valid, res
`ifdef CSA_RESOLVE_ZERO_EN
        , input zero
`endif
    );
endinterface
`default_nettype wire

// File: rtl/csa_resolve_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_resolve_pipe : pipelined carry-propagate add of a (sum, carry) pair  |
// | Optional build macro: CSA_RESOLVE_ZERO_EN (registered res==0 flag)       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csa_resolve_pipe #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input wire                 clk,
    input wire                 rst,
    csa_resolve_pipe_if.slave  bus_io
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int XW     = WIDTH + 2;
    localparam int LAST   = STAGES - 1;

    logic [XW-1:0]     a_src [STAGES];
    logic [XW-1:0]     b_src [STAGES];
    logic [XW-1:0]     s_src [STAGES];
    logic              c_src [STAGES];
    logic              v_src [STAGES];
    logic [XW-1:0]     s_d   [STAGES];
    logic              cy_d  [LAST];

    logic [XW-1:0]     a_q   [LAST];
    logic [XW-1:0]     b_q   [LAST];
    logic              cy_q  [LAST];
    logic [XW-1:0]     s_q   [STAGES];
    logic [STAGES-1:0] vld_q;

`ifdef CSA_RESOLVE_ZERO_EN
    logic              z_src [STAGES];
    logic              z_d   [STAGES];
    logic              z_q   [STAGES];
`endif

    logic              stage_en;

    assign stage_en         = ~vld_q[LAST] | bus_io.out_ready;
    assign bus_io.in_ready  = stage_en;
    assign bus_io.out_valid = vld_q[LAST];
    assign bus_io.res       = s_q[LAST];

    // a_q/b_q carry the operands forward (skew); s_q accumulates finished
    // low slices (de-skew), so slices at and above stage k are still zero.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_src[k] = {2'b00, bus_io.s_in};
            assign b_src[k] = {1'b0, bus_io.c_in, 1'b0};
            assign s_src[k] = '0;
            assign c_src[k] = 1'b0;
            assign v_src[k] = bus_io.in_valid;
`ifdef CSA_RESOLVE_ZERO_EN
            assign z_src[k] = 1'b1;
`endif
        end else begin : g_next
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
            assign c_src[k] = cy_q[k-1];
            assign v_src[k] = vld_q[k-1];
`ifdef CSA_RESOLVE_ZERO_EN
            assign z_src[k] = z_q[k-1];
`endif
        end

        if (k < LAST) begin : g_mid
            logic [CHUNK:0] w_sum;
            assign w_sum = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                         + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, c_src[k]};
            assign s_d[k]  = s_src[k] | (XW'(w_sum[CHUNK-1:0]) << (k*CHUNK));
            assign cy_d[k] = w_sum[CHUNK];
`ifdef CSA_RESOLVE_ZERO_EN
            assign z_d[k]  = z_src[k] & (w_sum[CHUNK-1:0] == '0);
`endif
        end else begin : g_last
            // Top slice also absorbs operand bits [XW-1:WIDTH]; it cannot overflow.
            logic [CHUNK+1:0] w_sum;
            assign w_sum = a_src[k][XW-1:k*CHUNK]
                         + b_src[k][XW-1:k*CHUNK]
                         + {{(CHUNK+1){1'b0}}, c_src[k]};
            assign s_d[k] = s_src[k] | (XW'(w_sum) << (k*CHUNK));
`ifdef CSA_RESOLVE_ZERO_EN
            assign z_d[k] = z_src[k] & (w_sum == '0);
`endif
        end
    end

    // Data only loads behind a valid bit, so bubbles never disturb res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
            for (int k = 0; k < LAST; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                cy_q[k] <= 1'b0;
            end
        end else if (stage_en) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= v_src[k];
                if (v_src[k]) begin
                    s_q[k] <= s_d[k];
                end
            end
            for (int k = 0; k < LAST; k++) begin
                if (v_src[k]) begin
                    a_q[k]  <= a_src[k];
                    b_q[k]  <= b_src[k];
                    cy_q[k] <= cy_d[k];
                end
            end
        end
    end

`ifdef CSA_RESOLVE_ZERO_EN
    assign bus_io.zero = z_q[LAST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                z_q[k] <= 1'b1;
            end
        end else if (stage_en) begin
            for (int k = 0; k < STAGES; k++) begin
                if (v_src[k]) begin
                    z_q[k] <= z_d[k];
                end
            end
        end
    end
`else
    // No zero-flag state exists in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csa_resolve_pipe : self-checking bench for csa_resolve_pipe           |
// | Honours CSA_RESOLVE_ZERO_EN when defined. Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module tb_csa_resolve_pipe;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_pop    = 0;
    int n_freeze = 0;

    logic [65:0] exp_q[$];
    int          pop_cyc_q[$];

    logic        snap_ok = 1'b0;
    logic        p_ov;
    logic        p_or;
    logic [65:0] p_res;
`ifdef CSA_RESOLVE_ZERO_EN
    logic        p_zero;
`endif

    csa_resolve_pipe_if #(.WIDTH(WIDTH)) bus();

    csa_resolve_pipe #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input bit ok, input string name,
                       input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [65:0] model(input logic [63:0] s, input logic [63:0] c);
        return 66'(s) + (66'(c) << 1);
    endfunction

    // Monitor: handshakes take effect at the following rising edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            snap_ok = 1'b0;
        end else begin
            chk(bus.in_ready == (!bus.out_valid || bus.out_ready), "in_ready rule",
                66'(bus.in_ready), 66'(!bus.out_valid || bus.out_ready));
            if (snap_ok && p_ov && !p_or) begin
                n_freeze++;
                chk(bus.out_valid == 1'b1, "stall out_valid held", 66'(bus.out_valid), 66'd1);
                chk(bus.res == p_res, "stall res held", bus.res, p_res);
`ifdef CSA_RESOLVE_ZERO_EN
                chk(bus.zero == p_zero, "stall zero held", 66'(bus.zero), 66'(p_zero));
`endif
            end
            if (snap_ok && !p_ov && !bus.out_valid)
                chk(bus.res == p_res, "idle res stable", bus.res, p_res);
            if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected output", bus.res, 66'd0);
                end else begin
                    logic [65:0] e;
                    e = exp_q.pop_front();
                    chk(bus.res == e, "model res", bus.res, e);
`ifdef CSA_RESOLVE_ZERO_EN
                    chk(bus.zero == (e == 66'd0), "model zero", 66'(bus.zero), 66'(e == 66'd0));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.s_in, bus.c_in));
            p_ov    = bus.out_valid;
            p_or    = bus.out_ready;
            p_res   = bus.res;
`ifdef CSA_RESOLVE_ZERO_EN
            p_zero  = bus.zero;
`endif
            snap_ok = 1'b1;
        end
    end

    // Single pair into an empty pipe; checks latency and a literal result.
    task automatic pulse_check(input logic [63:0] s, input logic [63:0] c,
                               input logic [65:0] lit, input string name);
        bit seen;
        seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.s_in     = s;
        bus.c_in     = c;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                chk(n == 4, {name, " latency"}, 66'(n), 66'd4);
                chk(bus.res == lit, {name, " res"}, bus.res, lit);
            end
        end
        if (!seen) chk(1'b0, {name, " timeout"}, 66'd0, 66'd1);
        @(posedge clk);
        #1;
    endtask

    // Presents a pair until the bench sees it accepted (bounded).
    task automatic send_hs(input logic [63:0] s, input logic [63:0] c);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.s_in     = s;
        bus.c_in     = c;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk(1'b0, "send timeout", 66'd0, 66'd1);
    endtask

    initial begin
        int pops0;
        int fr0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.s_in      = '0;
        bus.c_in      = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk(bus.out_valid == 1'b0, "reset out_valid", 66'(bus.out_valid), 66'd0);
        chk(bus.res == 66'd0, "reset res", bus.res, 66'd0);
`ifdef CSA_RESOLVE_ZERO_EN
        chk(bus.zero == 1'b1, "reset zero", 66'(bus.zero), 66'd1);
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        chk(bus.in_ready == 1'b1, "in_ready after release", 66'(bus.in_ready), 66'd1);
        @(posedge clk);
        #1;

        pulse_check(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 66'h0_FFFF_FFFF_FFFF_FFFF, "t1");
        pulse_check(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 66'h1_0000_0000_0000_0001, "t2");
        pulse_check(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    66'h2_FFFF_FFFF_FFFF_FFFD, "t3");
        pulse_check(64'h0, 64'h0, 66'h0, "t3 zero");
        pulse_check(64'h8000, 64'h4000, 66'h1_0000, "slice carry");

        // Back-to-back stream: outputs must land on consecutive cycles.
        pop_cyc_q.delete();
        pops0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.s_in     = {$urandom(), $urandom()};
            bus.c_in     = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk(n_pop - pops0 == 8, "t4 count", 66'(n_pop - pops0), 66'd8);
        if (pop_cyc_q.size() == 8)
            chk(pop_cyc_q[7] - pop_cyc_q[0] == 7, "t4 consecutive",
                66'(pop_cyc_q[7] - pop_cyc_q[0]), 66'd7);
        else
            chk(1'b0, "t4 pop records", 66'(pop_cyc_q.size()), 66'd8);

        // Stream with a five-cycle downstream stall in the middle.
        pops0 = n_pop;
        fr0   = n_freeze;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_hs({$urandom(), $urandom()}, {$urandom(), $urandom()});
                bus.in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        chk(n_pop - pops0 == 6, "t5 count", 66'(n_pop - pops0), 66'd6);
        chk(n_freeze - fr0 >= 4, "t5 stall seen", 66'(n_freeze - fr0), 66'd4);
        chk(exp_q.size() == 0, "t5 drained", 66'(exp_q.size()), 66'd0);

        // Reset with three pairs in flight: all are discarded.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.s_in     = {$urandom(), $urandom()} | 64'h1;
            bus.c_in     = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk(bus.out_valid == 1'b0, "t6 out_valid on reset", 66'(bus.out_valid), 66'd0);
        chk(bus.res == 66'd0, "t6 res on reset", bus.res, 66'd0);
`ifdef CSA_RESOLVE_ZERO_EN
        chk(bus.zero == 1'b1, "t6 zero on reset", 66'(bus.zero), 66'd1);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk(bus.in_ready == 1'b1, "t6 in_ready after release", 66'(bus.in_ready), 66'd1);
        @(posedge clk);
        #1;
        pulse_check(64'h1234, 64'h10, 66'h1254, "t6 post-reset");

        repeat (6) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "final drained", 66'(exp_q.size()), 66'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
